ipnuma_peer_regs: RTL and testbench
===================================

// Module: ipnuma_peer_regs
// PURPOSE
//  BAR0 control/status register bank for the IP-NUMA bridge, generalised to NUM_PEERS destination entries.
//  Host writes go to shadow copies; a commit FSM copies them atomically into active copies.
//  The copy waits until the requester is idle between packets.
//  Requester reads active entries through an indexed lookup port.
//  Sits between pcie_tlp slave bus (BAR0 hit) and requester.
// PARAMETERS
//  NUM_PEERS  4   destination entries, 1..16
//  IDX_W      2   lookup index width, >= clog2(NUM_PEERS), min 1
//  ADR_W      19  slave word-address MSB (slv_adr_i[ADR_W:1])
// PORTS
//  pcie_clk        in   1       clock
//  sys_rst         in   1       async reset, active-high
//  slv_hit_i       in   1       BAR0 hit (slv_bar_i[0])
//  slv_ce_i        in   1       slave cycle enable
//  slv_we_i        in   1       1=write, 0=read
//  slv_adr_i       in   ADR_W   word address [ADR_W:1]; only [9:1] decoded
//  slv_dat_i       in   16      write data
//  slv_sel_i       in   2       byte enables
//  slv_dat_o       out  16      read data, registered
//  req_idle_i      in   1       requester between packets
//  lk_idx_i        in   IDX_W   peer index for lookup
//  lk_valid_o      out  1       lookup data valid
//  lk_v4_o         out  32      active peer IPv4
//  lk_mac_o        out  48      active peer MAC
//  lk_paddr_o      out  48      active peer mem physical addr
//  if_v4addr_o     out  32      active interface IPv4
//  if_macaddr_o    out  48      active interface MAC
//  busy_o          out  1       commit in progress; requester must not start a packet
//  commit_done_o   out  1       1-cycle pulse at commit end
// BEHAVIOUR
//  Decoding and read data:
//   - Decode only when slv_hit_i & slv_ce_i. Word addr a=slv_adr_i[9:1].
//   - Read data appears on slv_dat_o 1 cycle after the access and holds until the next read.
//   - Writes honour slv_sel_i; sel[0] writes data[7:0], sel[1] writes data[15:8].
//  Address map (shadow registers, read/write):
//   - 0x000-0x001  if IPv4, high half first.
//   - 0x002-0x004  if MAC, high word first.
//   - 0x010 CTRL: write bit0=1 requests commit. Read gives {busy,pending,14'b0}.
//   - 0x011 STAT: read-only 16-bit commit counter, wraps 0xffff->0.
//   - Peer n at 0x040+8n:
//     - +0..+1 IPv4.
//     - +2..+4 MAC.
//     - +5..+7 paddr in 16-bit words [15:0],[31:16],[47:32], bytes swapped within each word.
//   - Peers n>=NUM_PEERS, unmapped reads and any access to 0x011 write: reads return 0, writes ignored.
//  Reset values:
//   - Shadow and active if_v4 = 10.0.21.199; if_mac = 00:37:76:00:00:01.
//   - Peer0 v4 = 10.0.21.255, MAC = ff:ff:ff:ff:ff:ff; all other peer fields and all paddr = 0.
//   - slv_dat_o=0, commit counter=0, pending=0, FSM=IDLE.
//   - lk_valid_o=1, busy_o=0, commit_done_o=0.
//   - Lookup outputs hold peer0 reset values.
//  Commit FSM states IDLE, WAIT, COPY, DONE:
//   - IDLE: commit request -> WAIT.
//   - WAIT: busy_o=1; go to COPY the first cycle req_idle_i=1.
//   - COPY: copy one entry per cycle, k=0..NUM_PEERS-1; interface regs are copied with k=0.
//     - After k=NUM_PEERS-1 -> DONE.
//   - DONE: pulse commit_done_o, increment counter.
//     - If pending=1: clear pending, -> WAIT. Else -> IDLE.
//  Concurrent writes:
//   - Commit request or any shadow write while not IDLE sets pending=1, so a further commit always follows.
//   - A commit request in the same cycle as the DONE state is treated as pending.
//  Lookup path:
//   - Active entry[lk_idx_i] is registered, 1-cycle latency.
//   - lk_valid_o=0 while state is COPY or DONE; 1 otherwise.
//   - lk_idx_i >= NUM_PEERS: returns zeros with lk_valid_o=1.
//  Reset asserted mid-commit: everything returns to reset values; a partial copy is discarded.
// STRUCTURE
//  - Shared package: constants for register offsets, PEER_BASE=9'h040, PEER_STRIDE=8, FSM state encoding,
//    reset address values.
//  - Sub-module ipnuma_peer_entry: one shadow+active entry with byte-enable writes and a copy strobe,
//    instantiated NUM_PEERS times by generate.
//  - Top holds decode, read mux, FSM and lookup register.
// TESTING
//  - Reset: read 0x000,0x001 -> 0x0a00,0x15c7; lk_idx=0 -> lk_mac=ffffffffffff, busy_o=0.
//  - Write peer1 0x048=0x0a00,0x049=0x1502 with no commit -> lookup idx1 still 0.
//    Then commit with req_idle=1 -> commit_done_o after NUM_PEERS+2 cycles; lk_v4=0x0a001502; STAT reads 1.
//  - Commit with req_idle_i held 0 for 50 cycles -> busy_o=1, no copy.
//    Raise req_idle_i -> copy starts next cycle.
//  - Write 0x04d=0x1234 sel=2'b01 only -> readback 0x0034.
//    After commit, lk_paddr_o[7:0]=0x00 and [15:8]=0x34.
//  - Shadow write during COPY -> pending=1, second commit runs back-to-back, STAT increments by 2.
//  - Assert sys_rst during COPY -> busy_o=0 immediately, active tables back to reset values.
//    Access to peer n=NUM_PEERS reads 0.

Source files
------------

// File: rtl/ipnuma_peer_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ipnuma_peer_regs_pkg
//  Purpose  : Shared constants, record type and helpers for the IP-NUMA
//             BAR0 peer register bank.
//  Revision : 1.0  initial release
// ============================================================================
package ipnuma_peer_regs_pkg;

  // Word addresses (slv_adr_i[9:1])
  localparam logic [8:0] ADR_IF_LAST = 9'h004;  // 0x000..0x004 are interface regs
  localparam logic [8:0] ADR_CTRL    = 9'h010;
  localparam logic [8:0] ADR_STAT    = 9'h011;
  localparam logic [8:0] PEER_BASE   = 9'h040;
  localparam int         PEER_STRIDE = 8;

  // Field offsets inside one entry (also the interface block layout)
  localparam logic [2:0] FLD_V4_HI   = 3'd0;
  localparam logic [2:0] FLD_V4_LO   = 3'd1;
  localparam logic [2:0] FLD_MAC_HI  = 3'd2;
  localparam logic [2:0] FLD_MAC_MID = 3'd3;
  localparam logic [2:0] FLD_MAC_LO  = 3'd4;
  localparam logic [2:0] FLD_PA_0    = 3'd5;
  localparam logic [2:0] FLD_PA_1    = 3'd6;
  localparam logic [2:0] FLD_PA_2    = 3'd7;

  // Commit FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_COPY = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Reset address values
  localparam logic [31:0] RST_IF_V4     = 32'h0a00_15c7;      // 10.0.21.199
  localparam logic [47:0] RST_IF_MAC    = 48'h0037_7600_0001; // 00:37:76:00:00:01
  localparam logic [31:0] RST_PEER0_V4  = 32'h0a00_15ff;      // 10.0.21.255
  localparam logic [47:0] RST_PEER0_MAC = 48'hffff_ffff_ffff;

  typedef struct packed {
    logic [31:0] v4;
    logic [47:0] mac;
    logic [47:0] paddr;
  } peer_t;

  // Byte-enable merge of a 16-bit register word
  function automatic logic [15:0] merge16(input logic [15:0] old,
                                          input logic [15:0] dat,
                                          input logic [1:0]  sel);
    return {sel[1] ? dat[15:8] : old[15:8], sel[0] ? dat[7:0] : old[7:0]};
  endfunction

  // Physical-address words are byte swapped between bus view and storage
  function automatic logic [15:0] swap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipnuma_peer_regs_if.sv
`default_nettype none
// ============================================================================
//  Module   : ipnuma_peer_regs_if
//  Purpose  : pcie_tlp slave bus (BAR0 side) as seen by the register bank.
//  Revision : 1.0  initial release
// ============================================================================
interface ipnuma_peer_regs_if #(
  parameter int ADR_W = 19
);
  logic             slv_hit_i;
  logic             slv_ce_i;
  logic             slv_we_i;
  logic [ADR_W:1]   slv_adr_i;
  logic [15:0]      slv_dat_i;
  logic [1:0]       slv_sel_i;
  logic [15:0]      slv_dat_o;

  modport master (
    output slv_hit_i, slv_ce_i, slv_we_i, slv_adr_i, slv_dat_i, slv_sel_i,
    input  slv_dat_o
  );

  modport slave (
    input  slv_hit_i, slv_ce_i, slv_we_i, slv_adr_i, slv_dat_i, slv_sel_i,
    output slv_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/ipnuma_peer_entry.sv
`default_nettype none
// ============================================================================
//  Module   : ipnuma_peer_entry
//  Purpose  : One shadow + active address record. Host writes land in the
//             shadow copy; copy_en moves the whole record to the active copy.
//  Revision : 1.0  initial release
// ============================================================================
module ipnuma_peer_entry
  import ipnuma_peer_regs_pkg::*;
#(
  parameter logic [31:0] RST_V4  = 32'h0,
  parameter logic [47:0] RST_MAC = 48'h0
) (
  input  wire         clk,
  input  wire         rst,
  input  wire         wr_en,
  input  wire  [2:0]  field,
  input  wire  [15:0] wr_dat,
  input  wire  [1:0]  wr_sel,
  input  wire         copy_en,
  output logic [15:0] rd_word,
  output peer_t       active
);

  localparam peer_t RST_ENTRY = '{v4: RST_V4, mac: RST_MAC, paddr: 48'h0};

  peer_t shadow;

  // Shadow byte writes and atomic copy; copy sees the pre-write shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= RST_ENTRY;
      active <= RST_ENTRY;
    end else begin
      if (copy_en)
        active <= shadow;
      if (wr_en) begin
        case (field)
          FLD_V4_HI:   shadow.v4[31:16]    <= merge16(shadow.v4[31:16], wr_dat, wr_sel);
          FLD_V4_LO:   shadow.v4[15:0]     <= merge16(shadow.v4[15:0], wr_dat, wr_sel);
          FLD_MAC_HI:  shadow.mac[47:32]   <= merge16(shadow.mac[47:32], wr_dat, wr_sel);
          FLD_MAC_MID: shadow.mac[31:16]   <= merge16(shadow.mac[31:16], wr_dat, wr_sel);
          FLD_MAC_LO:  shadow.mac[15:0]    <= merge16(shadow.mac[15:0], wr_dat, wr_sel);
          FLD_PA_0:    shadow.paddr[15:0]  <= swap16(merge16(swap16(shadow.paddr[15:0]), wr_dat, wr_sel));
          FLD_PA_1:    shadow.paddr[31:16] <= swap16(merge16(swap16(shadow.paddr[31:16]), wr_dat, wr_sel));
          FLD_PA_2:    shadow.paddr[47:32] <= swap16(merge16(swap16(shadow.paddr[47:32]), wr_dat, wr_sel));
          default: ;
        endcase
      end
    end
  end

  // Bus view of the shadow field selected by the current address
  always_comb begin
    rd_word = 16'h0;
    case (field)
      FLD_V4_HI:   rd_word = shadow.v4[31:16];
      FLD_V4_LO:   rd_word = shadow.v4[15:0];
      FLD_MAC_HI:  rd_word = shadow.mac[47:32];
      FLD_MAC_MID: rd_word = shadow.mac[31:16];
      FLD_MAC_LO:  rd_word = shadow.mac[15:0];
      FLD_PA_0:    rd_word = swap16(shadow.paddr[15:0]);
      FLD_PA_1:    rd_word = swap16(shadow.paddr[31:16]);
      FLD_PA_2:    rd_word = swap16(shadow.paddr[47:32]);
      default:     rd_word = 16'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ipnuma_peer_regs.sv
`default_nettype none
// ============================================================================
//  Module   : ipnuma_peer_regs
//  Purpose  : BAR0 control/status bank of the IP-NUMA bridge. Shadow peer
//             and interface records are committed atomically into active
//             copies while the requester sits between packets.
//  Revision : 1.0  initial release
// ============================================================================
module ipnuma_peer_regs
  import ipnuma_peer_regs_pkg::*;
#(
  parameter int NUM_PEERS = 4,
  parameter int IDX_W     = 2,
  parameter int ADR_W     = 19
) (
  input  wire              pcie_clk,
  input  wire              sys_rst,
  ipnuma_peer_regs_if.slave slv,
  input  wire              req_idle_i,
  input  wire  [IDX_W-1:0] lk_idx_i,
  output logic             lk_valid_o,
  output logic [31:0]      lk_v4_o,
  output logic [47:0]      lk_mac_o,
  output logic [47:0]      lk_paddr_o,
  output logic [31:0]      if_v4addr_o,
  output logic [47:0]      if_macaddr_o,
  output logic             busy_o,
  output logic             commit_done_o
);

  localparam int K_W       = (NUM_PEERS > 1) ? $clog2(NUM_PEERS) : 1;
  localparam int STRIDE_SH = $clog2(PEER_STRIDE);

  // Decode
  logic       acc, wr_acc, rd_acc;
  logic [8:0] adr, peer_off, peer_n;
  logic [2:0] field;
  logic       in_if, in_peer;
  logic       commit_req, shd_wr, set_pend;

  assign acc      = slv.slv_hit_i & slv.slv_ce_i;
  assign wr_acc   = acc & slv.slv_we_i;
  assign rd_acc   = acc & ~slv.slv_we_i;
  assign adr      = slv.slv_adr_i[9:1];
  assign peer_off = adr - PEER_BASE;
  assign peer_n   = peer_off >> STRIDE_SH;
  assign field    = peer_off[2:0];
  assign in_if    = (adr <= ADR_IF_LAST);
  assign in_peer  = (adr >= PEER_BASE) && (peer_n < 9'(NUM_PEERS));

  assign commit_req = wr_acc && (adr == ADR_CTRL) && slv.slv_sel_i[0] && slv.slv_dat_i[0];
  assign shd_wr     = wr_acc && (in_if || in_peer);
  assign set_pend   = commit_req || shd_wr;

  generate
    if (ADR_W > 9) begin : g_adr_hi
      logic unused_adr_hi;
      assign unused_adr_hi = ^slv.slv_adr_i[ADR_W:10];
    end
  endgenerate

  // Commit FSM state
  logic [1:0]     state;
  logic [K_W-1:0] copy_k;
  logic           pending;
  logic [15:0]    commit_cnt;
  logic           copy_strobe;

  assign copy_strobe   = (state == ST_COPY);
  assign busy_o        = (state != ST_IDLE);
  assign commit_done_o = (state == ST_DONE);
  assign lk_valid_o    = !((state == ST_COPY) || (state == ST_DONE));

  // Entries
  peer_t       peer_act [NUM_PEERS];
  logic [15:0] peer_rd  [NUM_PEERS];
  peer_t       if_act;
  logic [15:0] if_rd;
  logic        unused_if_paddr;

  ipnuma_peer_entry #(
    .RST_V4  (RST_IF_V4),
    .RST_MAC (RST_IF_MAC)
  ) u_if_entry (
    .clk     (pcie_clk),
    .rst     (sys_rst),
    .wr_en   (wr_acc && in_if),
    .field   (field),
    .wr_dat  (slv.slv_dat_i),
    .wr_sel  (slv.slv_sel_i),
    .copy_en (copy_strobe && (copy_k == '0)),
    .rd_word (if_rd),
    .active  (if_act)
  );

  // The interface record has no physical address
  assign unused_if_paddr = ^if_act.paddr;
  assign if_v4addr_o     = if_act.v4;
  assign if_macaddr_o    = if_act.mac;

  generate
    for (genvar g = 0; g < NUM_PEERS; g++) begin : g_peer
      ipnuma_peer_entry #(
        .RST_V4  ((g == 0) ? RST_PEER0_V4  : 32'h0),
        .RST_MAC ((g == 0) ? RST_PEER0_MAC : 48'h0)
      ) u_entry (
        .clk     (pcie_clk),
        .rst     (sys_rst),
        .wr_en   (wr_acc && in_peer && (peer_n == 9'(g))),
        .field   (field),
        .wr_dat  (slv.slv_dat_i),
        .wr_sel  (slv.slv_sel_i),
        .copy_en (copy_strobe && (copy_k == K_W'(g))),
        .rd_word (peer_rd[g]),
        .active  (peer_act[g])
      );
    end
  endgenerate

  // Commit sequencing: wait for idle requester, copy one entry per cycle
  always_ff @(posedge pcie_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      copy_k     <= '0;
      pending    <= 1'b0;
      commit_cnt <= 16'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (commit_req)
            state <= ST_WAIT;
        end
        ST_WAIT: begin
          copy_k <= '0;
          if (set_pend)
            pending <= 1'b1;
          if (req_idle_i)
            state <= ST_COPY;
        end
        ST_COPY: begin
          copy_k <= copy_k + 1'b1;
          if (set_pend)
            pending <= 1'b1;
          if (copy_k == K_W'(NUM_PEERS - 1))
            state <= ST_DONE;
        end
        ST_DONE: begin
          commit_cnt <= commit_cnt + 16'h1;
          pending    <= 1'b0;
          state      <= (pending || set_pend) ? ST_WAIT : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data mux over shadow registers, control and status
  logic [15:0] rd_word;
  always_comb begin
    rd_word = 16'h0;
    if (in_if)
      rd_word = if_rd;
    else if (adr == ADR_CTRL)
      rd_word = {busy_o, pending, 14'b0};
    else if (adr == ADR_STAT)
      rd_word = commit_cnt;
    else if (in_peer)
      for (int i = 0; i < NUM_PEERS; i++)
        if (peer_n == 9'(i))
          rd_word = peer_rd[i];
  end

  // Registered read data, held until the next read
  always_ff @(posedge pcie_clk or posedge sys_rst) begin
    if (sys_rst)
      slv.slv_dat_o <= 16'h0;
    else if (rd_acc)
      slv.slv_dat_o <= rd_word;
  end

  // Lookup of the active entry; out-of-range indices read as zero
  peer_t lk_next, lk_q;
  always_comb begin
    lk_next = '0;
    for (int i = 0; i < NUM_PEERS; i++)
      if (lk_idx_i == IDX_W'(i))
        lk_next = peer_act[i];
  end

  // One-cycle lookup register
  always_ff @(posedge pcie_clk or posedge sys_rst) begin
    if (sys_rst)
      lk_q <= '{v4: RST_PEER0_V4, mac: RST_PEER0_MAC, paddr: 48'h0};
    else
      lk_q <= lk_next;
  end

  assign lk_v4_o    = lk_q.v4;
  assign lk_mac_o   = lk_q.mac;
  assign lk_paddr_o = lk_q.paddr;

endmodule
`default_nettype wire

// File: tb/tb_ipnuma_peer_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ipnuma_peer_regs
//  Purpose  : Self-checking bench for ipnuma_peer_regs with a word-level
//             reference model of the register bank and commit sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ipnuma_peer_regs;

  localparam int NUM_PEERS = 4;
  localparam int IDX_W     = 3;
  localparam int ADR_W     = 19;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_idle;
  logic [IDX_W-1:0] lk_idx;
  logic             lk_valid, busy, done;
  logic [31:0]      lk_v4, if_v4;
  logic [47:0]      lk_mac, lk_paddr, if_mac;

  ipnuma_peer_regs_if #(.ADR_W(ADR_W)) bus ();

  ipnuma_peer_regs #(
    .NUM_PEERS (NUM_PEERS),
    .IDX_W     (IDX_W),
    .ADR_W     (ADR_W)
  ) dut (
    .pcie_clk      (clk),
    .sys_rst       (rst),
    .slv           (bus),
    .req_idle_i    (req_idle),
    .lk_idx_i      (lk_idx),
    .lk_valid_o    (lk_valid),
    .lk_v4_o       (lk_v4),
    .lk_mac_o      (lk_mac),
    .lk_paddr_o    (lk_paddr),
    .if_v4addr_o   (if_v4),
    .if_macaddr_o  (if_mac),
    .busy_o        (busy),
    .commit_done_o (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Shadow registers are held exactly as the host reads them back.
  logic [15:0] m_if   [5];
  logic [15:0] m_peer [NUM_PEERS][8];
  logic [31:0] m_act_if_v4;
  logic [47:0] m_act_if_mac;
  logic [31:0] m_act_v4    [NUM_PEERS];
  logic [47:0] m_act_mac   [NUM_PEERS];
  logic [47:0] m_act_paddr [NUM_PEERS];
  bit          m_in_commit, m_pending;
  int          m_pos;      // -1 waiting for idle, 0..N-1 entry being copied, N finishing
  logic [15:0] m_cnt;
  logic [15:0] e_dat;
  logic [31:0] e_lk_v4;
  logic [47:0] e_lk_mac, e_lk_paddr;

  function automatic logic [15:0] bsw(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  function automatic logic [15:0] bmerge(input logic [15:0] o, input logic [15:0] d, input logic [1:0] s);
    logic [15:0] r;
    r = o;
    if (s[0]) r[7:0]  = d[7:0];
    if (s[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  task automatic copy_peer(input int n);
    m_act_v4[n]    = {m_peer[n][0], m_peer[n][1]};
    m_act_mac[n]   = {m_peer[n][2], m_peer[n][3], m_peer[n][4]};
    m_act_paddr[n] = {bsw(m_peer[n][7]), bsw(m_peer[n][6]), bsw(m_peer[n][5])};
  endtask

  task automatic copy_if();
    m_act_if_v4  = {m_if[0], m_if[1]};
    m_act_if_mac = {m_if[2], m_if[3], m_if[4]};
  endtask

  task automatic model_reset();
    m_if = '{16'h0a00, 16'h15c7, 16'h0037, 16'h7600, 16'h0001};
    for (int n = 0; n < NUM_PEERS; n++)
      for (int w = 0; w < 8; w++)
        m_peer[n][w] = 16'h0;
    m_peer[0][0] = 16'h0a00;
    m_peer[0][1] = 16'h15ff;
    m_peer[0][2] = 16'hffff;
    m_peer[0][3] = 16'hffff;
    m_peer[0][4] = 16'hffff;
    copy_if();
    for (int n = 0; n < NUM_PEERS; n++) copy_peer(n);
    m_in_commit = 0;
    m_pending   = 0;
    m_pos       = 0;
    m_cnt       = 16'h0;
    e_dat       = 16'h0;
    e_lk_v4     = 32'h0a00_15ff;
    e_lk_mac    = 48'hffff_ffff_ffff;
    e_lk_paddr  = 48'h0;
  endtask

  function automatic logic [15:0] model_read(input int a);
    if (a <= 4) return m_if[a];
    if (a == 16) return {m_in_commit, m_pending, 14'b0};
    if (a == 17) return m_cnt;
    if (a >= 64 && a < 64 + 8 * NUM_PEERS) return m_peer[(a - 64) / 8][(a - 64) % 8];
    return 16'h0;
  endfunction

  // Advance the model across one rising edge using the inputs now driven
  task automatic model_step();
    bit wr, rd, map_if, map_peer, req, sw;
    int a;
    wr       = bus.slv_hit_i && bus.slv_ce_i && bus.slv_we_i;
    rd       = bus.slv_hit_i && bus.slv_ce_i && !bus.slv_we_i;
    a        = int'(bus.slv_adr_i[9:1]);
    map_if   = wr && (a <= 4);
    map_peer = wr && (a >= 64) && (a < 64 + 8 * NUM_PEERS);
    req      = wr && (a == 16) && bus.slv_sel_i[0] && bus.slv_dat_i[0];
    sw       = map_if || map_peer;
    if (rd) e_dat = model_read(a);
    if (int'(lk_idx) < NUM_PEERS) begin
      e_lk_v4    = m_act_v4[int'(lk_idx)];
      e_lk_mac   = m_act_mac[int'(lk_idx)];
      e_lk_paddr = m_act_paddr[int'(lk_idx)];
    end else begin
      e_lk_v4    = 32'h0;
      e_lk_mac   = 48'h0;
      e_lk_paddr = 48'h0;
    end
    if (!m_in_commit) begin
      if (req) begin
        m_in_commit = 1;
        m_pos       = -1;
      end
    end else if (m_pos < 0) begin
      if (req || sw) m_pending = 1;
      if (req_idle) m_pos = 0;
    end else if (m_pos < NUM_PEERS) begin
      if (m_pos == 0) copy_if();
      copy_peer(m_pos);
      if (req || sw) m_pending = 1;
      m_pos++;
    end else begin
      m_cnt++;
      if (m_pending || req || sw) m_pos = -1;
      else m_in_commit = 0;
      m_pending = 0;
    end
    if (map_if) m_if[a] = bmerge(m_if[a], bus.slv_dat_i, bus.slv_sel_i);
    if (map_peer) m_peer[(a - 64) / 8][(a - 64) % 8] =
        bmerge(m_peer[(a - 64) / 8][(a - 64) % 8], bus.slv_dat_i, bus.slv_sel_i);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("slv_dat_o",     64'(bus.slv_dat_o), 64'(e_dat));
    check("lk_v4_o",       64'(lk_v4),         64'(e_lk_v4));
    check("lk_mac_o",      64'(lk_mac),        64'(e_lk_mac));
    check("lk_paddr_o",    64'(lk_paddr),      64'(e_lk_paddr));
    check("if_v4addr_o",   64'(if_v4),         64'(m_act_if_v4));
    check("if_macaddr_o",  64'(if_mac),        64'(m_act_if_mac));
    check("busy_o",        64'(busy),          64'(m_in_commit));
    check("commit_done_o", 64'(done),          64'(m_in_commit && m_pos == NUM_PEERS));
    check("lk_valid_o",    64'(lk_valid),      64'(!(m_in_commit && m_pos >= 0)));
  endtask

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_bus();
    bus.slv_hit_i = 1'b0;
    bus.slv_ce_i  = 1'b0;
    bus.slv_we_i  = 1'b0;
    bus.slv_adr_i = '0;
    bus.slv_dat_i = 16'h0;
    bus.slv_sel_i = 2'b00;
  endtask

  task automatic bus_write(input int a, input logic [15:0] d, input logic [1:0] s);
    bus.slv_hit_i = 1'b1;
    bus.slv_ce_i  = 1'b1;
    bus.slv_we_i  = 1'b1;
    bus.slv_adr_i = '0;
    bus.slv_adr_i[9:1] = 9'(a);
    bus.slv_dat_i = d;
    bus.slv_sel_i = s;
    cycle();
    idle_bus();
  endtask

  task automatic bus_read(input int a, output logic [15:0] v);
    bus.slv_hit_i = 1'b1;
    bus.slv_ce_i  = 1'b1;
    bus.slv_we_i  = 1'b0;
    bus.slv_adr_i = '0;
    bus.slv_adr_i[9:1] = 9'(a);
    cycle();
    v = bus.slv_dat_o;
    idle_bus();
  endtask

  task automatic wait_done(input int limit);
    int c;
    c = 0;
    while (!done && c < limit) begin
      cycle();
      c++;
    end
    check("commit_done_seen", 64'(done), 64'(1));
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("busy_after_async_rst",  64'(busy),     64'(0));
    check("valid_after_async_rst", 64'(lk_valid), 64'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v, s0;
    int c;
    idle_bus();
    req_idle = 1'b1;
    lk_idx   = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();

    // Reset contents
    bus_read(16'h000, v); check("rst_if_v4_hi", 64'(v), 64'h0a00);
    bus_read(16'h001, v); check("rst_if_v4_lo", 64'(v), 64'h15c7);
    check("rst_lk_mac", 64'(lk_mac), 64'hffff_ffff_ffff);
    check("rst_busy",   64'(busy),   64'h0);

    // Shadow writes are invisible until committed
    bus_write(16'h048, 16'h0a00, 2'b11);
    bus_write(16'h049, 16'h1502, 2'b11);
    lk_idx = 3'd1;
    cycle();
    check("peer1_before_commit", 64'(lk_v4), 64'h0);
    bus_write(16'h010, 16'h0001, 2'b11);
    c = 1;
    while (!done && c < 40) begin
      cycle();
      c++;
    end
    check("commit_latency", 64'(c), 64'(NUM_PEERS + 2));
    cycle();
    cycle();
    check("peer1_after_commit", 64'(lk_v4), 64'h0a00_1502);
    bus_read(16'h011, v); check("stat_after_one", 64'(v), 64'h1);

    // Commit stalls while the requester is busy
    req_idle = 1'b0;
    bus_write(16'h010, 16'h0001, 2'b01);
    repeat (50) cycle();
    check("busy_while_stalled", 64'(busy), 64'h1);
    req_idle = 1'b1;
    cycle();
    check("copy_starts_next_cycle", 64'(lk_valid), 64'h0);
    wait_done(20);

    // Partial byte write of a byte-swapped paddr word
    bus_write(16'h04d, 16'h1234, 2'b01);
    bus_read(16'h04d, v); check("paddr_partial_readback", 64'(v), 64'h0034);
    bus_write(16'h010, 16'h0001, 2'b11);
    wait_done(20);
    cycle();
    cycle();
    check("paddr_active_low16", 64'(lk_paddr[15:0]), 64'h3400);

    // Shadow write during COPY forces a back-to-back second commit
    bus_read(16'h011, s0);
    bus_write(16'h010, 16'h0001, 2'b11);
    cycle();
    bus_write(16'h040, 16'h1111, 2'b11);
    bus_read(16'h010, v); check("ctrl_busy_pending", 64'(v), 64'hc000);
    c = 0;
    while (busy && c < 100) begin
      cycle();
      c++;
    end
    check("second_commit_ends", 64'(busy), 64'h0);
    bus_read(16'h011, v); check("stat_plus_two", 64'(v), 64'(s0 + 16'd2));

    // Reset in the middle of COPY discards the partial copy
    lk_idx = 3'd0;
    bus_write(16'h040, 16'hbeef, 2'b11);
    bus_write(16'h010, 16'h0001, 2'b11);
    cycle();
    cycle();
    async_reset();
    cycle();
    cycle();
    check("rst_peer0_v4_restored", 64'(lk_v4), 64'h0a00_15ff);
    check("rst_if_v4_restored",    64'(if_v4), 64'h0a00_15c7);
    bus_write(NUM_PEERS * 8 + 64, 16'h5a5a, 2'b11);
    bus_read(NUM_PEERS * 8 + 64, v); check("peer_n_out_of_range", 64'(v), 64'h0);
    bus_write(16'h011, 16'h5555, 2'b11);
    bus_read(16'h011, v); check("stat_write_ignored", 64'(v), 64'h0);
    lk_idx = 3'd5;
    cycle();
    cycle();
    check("lk_idx_out_of_range", 64'(lk_mac), 64'h0);

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r, a;
      if ($urandom_range(0, 799) == 0) async_reset();
      r = $urandom_range(0, 9);
      case (r)
        0, 1:       a = $urandom_range(0, 4);
        2:          a = 16;
        3:          a = 17;
        4, 5, 6, 7: a = 64 + $urandom_range(0, 8 * (NUM_PEERS + 1) - 1);
        default:    a = $urandom_range(0, 511);
      endcase
      bus.slv_hit_i = ($urandom_range(0, 7) != 0);
      bus.slv_ce_i  = ($urandom_range(0, 3) != 0);
      bus.slv_we_i  = $urandom_range(0, 1) == 1;
      bus.slv_adr_i = ADR_W'($urandom);
      bus.slv_adr_i[9:1] = 9'(a);
      bus.slv_dat_i = 16'($urandom);
      bus.slv_sel_i = 2'($urandom);
      req_idle      = ($urandom_range(0, 3) != 0);
      lk_idx        = IDX_W'($urandom);
      cycle();
    end
    idle_bus();
    req_idle = 1'b1;
    repeat (30) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
